// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART frame receiver
// Gray-coded FSM states, legal prescale ratios and parity-type encodings.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_START  = 3'b001;
  localparam logic [2:0] ST_DATA   = 3'b011;
  localparam logic [2:0] ST_PARITY = 3'b010;
  localparam logic [2:0] ST_STOP   = 3'b110;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity bit the transmitter must send, given the XOR of the payload.
  function automatic logic parity_expect(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - serial line, frame configuration and received-byte outputs
// master = line driver / byte consumer, slave = receiver.
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      RX_IN;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      Par_Err;
  logic                      Stp_Err;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, Data_Valid, Par_Err, Stp_Err
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, Data_Valid, Par_Err, Stp_Err
  );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversample edge counter, data bit counter and prescale capture
// UART_RX_MAJORITY_EN adds the early side-sample strobe at edge_cnt P/2-1.
module uart_rx_edge_bit_cnt
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic                      active_i,
  input  logic                      data_state_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      sample_strobe_o,
  output logic                      mid_strobe_o,
`ifdef UART_RX_MAJORITY_EN
  output logic                      lo_strobe_o,
`endif
  output logic                      bit_done_o,
  output logic                      last_data_bit_o
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_WIDTH-1:0] P8  = PRESCALE_WIDTH'(PRESCALE_8);
  localparam logic [PRESCALE_WIDTH-1:0] P16 = PRESCALE_WIDTH'(PRESCALE_16);
  localparam logic [PRESCALE_WIDTH-1:0] P32 = PRESCALE_WIDTH'(PRESCALE_32);

  logic [PRESCALE_WIDTH-1:0] p_q, p_fold, edge_cnt_q, half;
  logic [BIT_W-1:0]          bit_cnt_q;

  // Anything other than a legal ratio falls back to the slowest-to-break setting, 8.
  always_comb begin
    p_fold = P8;
    if (prescale_i == P16) p_fold = P16;
    if (prescale_i == P32) p_fold = P32;
  end

  assign half = p_q >> 1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p_q        <= P8;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      if (start_i) p_q <= p_fold;

      if (!active_i || bit_done_o) edge_cnt_q <= '0;
      else                         edge_cnt_q <= edge_cnt_q + PRESCALE_WIDTH'(1);

      if (!data_state_i)   bit_cnt_q <= '0;
      else if (bit_done_o) bit_cnt_q <= bit_cnt_q + BIT_W'(1);
    end
  end

  assign sample_strobe_o = active_i && (edge_cnt_q == half + PRESCALE_WIDTH'(1));
  assign mid_strobe_o    = active_i && (edge_cnt_q == half);
`ifdef UART_RX_MAJORITY_EN
  assign lo_strobe_o     = active_i && (edge_cnt_q == half - PRESCALE_WIDTH'(1));
`endif
  assign bit_done_o      = active_i && (edge_cnt_q == p_q - PRESCALE_WIDTH'(1));
  assign last_data_bit_o = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART frame receiver: synchronizer, FSM, sampler, deserializer, checkers
// UART_RX_MAJORITY_EN selects 3-sample majority bit decisions; default is a single mid-bit sample.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  uart_rx_frame_if.slave  rx_if
);

  logic sync1_q, sync2_q, rx_prev_q, rx_s, fall;
  logic [2:0] state_q, state_d;
  logic sample_strobe, mid_strobe, bit_done, last_data_bit, bit_val;
  logic samp_mid_q;
`ifdef UART_RX_MAJORITY_EN
  logic samp_lo_q, lo_strobe;
`endif
  logic par_en_q, par_typ_q, par_bad_q;
  logic [DATA_WIDTH-1:0] shift_q, p_data_q;
  logic shift_en, par_latch, cfg_capture;
  logic data_valid_q, data_valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_if.RX_IN;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx_s = sync2_q;
  assign fall = rx_prev_q & ~rx_s;

  uart_rx_edge_bit_cnt #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_cnt (
    .clk_i           (i_CLK),
    .rst_n_i         (i_RST),
    .start_i         (cfg_capture),
    .active_i        (state_q != ST_IDLE),
    .data_state_i    (state_q == ST_DATA),
    .prescale_i      (rx_if.Prescale),
    .sample_strobe_o (sample_strobe),
    .mid_strobe_o    (mid_strobe),
`ifdef UART_RX_MAJORITY_EN
    .lo_strobe_o     (lo_strobe),
`endif
    .bit_done_o      (bit_done),
    .last_data_bit_o (last_data_bit)
  );

  // Side samples are held in flops; the P/2+1 sample is the live line at the decision point.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      samp_mid_q <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      samp_lo_q  <= 1'b1;
`endif
    end else begin
      if (mid_strobe) samp_mid_q <= rx_s;
`ifdef UART_RX_MAJORITY_EN
      if (lo_strobe)  samp_lo_q  <= rx_s;
`endif
    end
  end

`ifdef UART_RX_MAJORITY_EN
  assign bit_val = (samp_lo_q & samp_mid_q) | (samp_lo_q & rx_s) | (samp_mid_q & rx_s);
`else
  assign bit_val = samp_mid_q;
`endif

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fall) state_d = ST_START;
      ST_START: begin
        if (sample_strobe && bit_val) state_d = ST_IDLE;
        else if (bit_done)            state_d = ST_DATA;
      end
      ST_DATA:   if (bit_done && last_data_bit) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done) state_d = ST_STOP;
      // Leave half a bit early so a back-to-back start edge is never missed.
      ST_STOP:   if (sample_strobe) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_en     = 1'b0;
    par_latch    = 1'b0;
    cfg_capture  = 1'b0;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    case (state_q)
      ST_IDLE:   cfg_capture = fall;
      ST_DATA:   shift_en    = sample_strobe;
      ST_PARITY: par_latch   = sample_strobe;
      ST_STOP: begin
        if (sample_strobe) begin
          data_valid_d = bit_val & ~par_bad_q;
          stp_err_d    = ~bit_val;
          par_err_d    = par_bad_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      if (cfg_capture) begin
        par_en_q  <= rx_if.PAR_EN;
        par_typ_q <= rx_if.PAR_TYP;
        par_bad_q <= 1'b0;
      end
      if (shift_en)  shift_q   <= {bit_val, shift_q[DATA_WIDTH-1:1]};
      if (par_latch) par_bad_q <= bit_val ^ parity_expect(^shift_q, par_typ_q);
      if (data_valid_d) p_data_q <= shift_q;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign rx_if.P_DATA     = p_data_q;
  assign rx_if.Data_Valid = data_valid_q;
  assign rx_if.Par_Err    = par_err_q;
  assign rx_if.Stp_Err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame
// With UART_RX_MAJORITY_EN defined, also sends a frame with a 1-cycle mid-bit inversion on every data bit.
module tb_uart_rx_frame;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frame_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

  uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .i_CLK (clk),
    .i_RST (rst_n),
    .rx_if (bus.slave)
  );

  typedef struct {
    logic        v;
    logic        pe;
    logic        se;
    logic [7:0]  data;
    int unsigned t;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int          p = 8;
  logic [7:0]  last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outcome is pushed on the stop-bit's first cycle; the pulse is due P/2+5 negedges later
  // (2 synchronizer flops + edge detect, then P/2+2 cycles into the stop bit).
  task automatic drive_bit(input logic b, input logic g, input logic push, input exp_t e);
    for (int c = 0; c < p; c++) begin
      @(negedge clk);
      if (push && c == 0) begin
        e.t = cyc + unsigned'(p / 2 + 5);
        sb_q.push_back(e);
      end
      bus.RX_IN = (g && c == p / 2 + 1) ? ~b : b;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_b, input logic g);
    exp_t e;
    logic pbad;
    e.v = 1'b0; e.pe = 1'b0; e.se = 1'b0; e.data = 8'h00; e.t = 0;
    drive_bit(1'b0, 1'b0, 1'b0, e);
    for (int i = 0; i < 8; i++) drive_bit(d[i], g, 1'b0, e);
    pbad = bus.PAR_EN & bad_par;
    if (bus.PAR_EN) drive_bit((^d) ^ bus.PAR_TYP ^ bad_par, 1'b0, 1'b0, e);
    e.v  = stop_b & ~pbad;
    e.pe = pbad;
    e.se = ~stop_b;
    if (e.v) last_good = d;
    e.data = last_good;
    drive_bit(stop_b, 1'b0, 1'b1, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
    check_eq(tag, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    idle(2 * p);
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.Data_Valid || bus.Par_Err || bus.Stp_Err)) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_pulse", 32'({bus.Data_Valid, bus.Par_Err, bus.Stp_Err}), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("data_valid", 32'(bus.Data_Valid), 32'(mon_e.v));
        check_eq("par_err",    32'(bus.Par_Err),    32'(mon_e.pe));
        check_eq("stp_err",    32'(bus.Stp_Err),    32'(mon_e.se));
        check_eq("p_data",     32'(bus.P_DATA),     32'(mon_e.data));
        check_eq("latency",    32'(cyc),            32'(mon_e.t));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.RX_IN = 1'b1; bus.Prescale = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    rst_n = 1'b0;
    idle(4);
    check_eq("rst_p_data", 32'(bus.P_DATA),     32'd0);
    check_eq("rst_dv",     32'(bus.Data_Valid), 32'd0);
    check_eq("rst_pe",     32'(bus.Par_Err),    32'd0);
    check_eq("rst_se",     32'(bus.Stp_Err),    32'd0);
    rst_n = 1'b1;
    idle(10);

    p = 8;
    send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
    drain("t1_drain");

    p = 16; bus.Prescale = 6'd16; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
    send_frame(8'h5D, 1'b0, 1'b1, 1'b0);
    drain("t2_good_drain");
    send_frame(8'h5D, 1'b1, 1'b1, 1'b0);
    drain("t2_bad_drain");
    bus.PAR_TYP = 1'b1;
    send_frame(8'h5D, 1'b0, 1'b1, 1'b0);
    drain("t2_odd_drain");

    p = 32; bus.Prescale = 6'd32; bus.PAR_EN = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(2 * p);
    drain("t3_stop_drain");
    bus.RX_IN = 1'b1;
    idle(2 * p);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    drain("t3_good_drain");

    p = 8; bus.Prescale = 6'd8;
    @(negedge clk); bus.RX_IN = 1'b0;
    idle(p / 4);
    bus.RX_IN = 1'b1;
    idle(4 * p);
    send_frame(8'hBB, 1'b0, 1'b1, 1'b0);
    drain("t4_drain");

    send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
    send_frame(8'h05, 1'b0, 1'b1, 1'b0);
    send_frame(8'hCC, 1'b0, 1'b1, 1'b0);
    drain("t5_drain");

    bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
    send_frame(8'h71, 1'b1, 1'b0, 1'b0);
    bus.RX_IN = 1'b1;
    drain("both_err_drain");

    bus.PAR_EN = 1'b0; bus.Prescale = 6'd20;
    send_frame(8'h96, 1'b0, 1'b1, 1'b0);
    drain("illegal_ps_drain");
    bus.Prescale = 6'd8;

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h6B, 1'b0, 1'b1, 1'b1);
    drain("majority_drain");
`endif

    begin
      exp_t e;
      e.v = 1'b0; e.pe = 1'b0; e.se = 1'b0; e.data = 8'h00; e.t = 0;
      drive_bit(1'b0, 1'b0, 1'b0, e);
      for (int i = 0; i < 4; i++) drive_bit(bit'(8'hDD >> i), 1'b0, 1'b0, e);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        bus.RX_IN = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      last_good = 8'h00;
      check_eq("midrst_p_data", 32'(bus.P_DATA),     32'd0);
      check_eq("midrst_dv",     32'(bus.Data_Valid), 32'd0);
      check_eq("midrst_pe",     32'(bus.Par_Err),    32'd0);
      check_eq("midrst_se",     32'(bus.Stp_Err),    32'd0);
      bus.RX_IN = 1'b1;
      idle(5);
      rst_n = 1'b1;
      idle(3 * p);
    end
    send_frame(8'hDD, 1'b0, 1'b1, 1'b0);
    drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
